// File: rtl/flow_power_frame.sv
// Instantaneous power I^2+Q^2 in a two-stage pipeline, sliced into fixed-length
// frames with tlast, bin index, completed-frame count and short-frame flagging.
module flow_power_frame #(
  parameter int IW        = 16,
  parameter int DATAWIDTH = 64,
  parameter int AWIDTH    = 8,
  parameter int FRAME_LEN = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IW-1:0]        din_i,
  input  logic [IW-1:0]        din_q,
  input  logic                 din_tvalid,
  input  logic                 din_sof,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 dout_tvalid,
  output logic                 dout_tlast,
  output logic [AWIDTH-1:0]    dout_index,
  output logic [15:0]          frame_cnt,
  output logic                 err_short
);

  localparam int PW = 2 * IW;
  localparam logic [AWIDTH-1:0] LAST_BIN = AWIDTH'(FRAME_LEN - 1);

  logic [AWIDTH-1:0]    bin_cnt_q, bin_cnt_d;
  logic                 v1_q, v1_d;
  logic                 last1_q, last1_d;
  logic                 err1_q, err1_d;
  logic [AWIDTH-1:0]    idx1_q, idx1_d;
  logic [PW-1:0]        ii_q, ii_d;
  logic [PW-1:0]        qq_q, qq_d;
  logic [PW-1:0]        ie_s, qe_s;
  logic [PW:0]          sum_s;

  logic [DATAWIDTH-1:0] dout_q, dout_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic [AWIDTH-1:0]    index_q, index_d;
  logic                 err_q, err_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;

  // Stage 1: sign-extend so the low PW bits of the square are exact, then tag framing sideband.
  always_comb begin
    ie_s      = {{IW{din_i[IW-1]}}, din_i};
    qe_s      = {{IW{din_q[IW-1]}}, din_q};
    bin_cnt_d = bin_cnt_q;
    v1_d      = din_tvalid;
    last1_d   = 1'b0;
    err1_d    = 1'b0;
    idx1_d    = '0;
    ii_d      = '0;
    qq_d      = '0;
    if (din_tvalid) begin
      ii_d = ie_s * ie_s;
      qq_d = qe_s * qe_s;
      if (din_sof) begin
        err1_d    = (bin_cnt_q != '0);
        bin_cnt_d = AWIDTH'(1);
      end else begin
        idx1_d = bin_cnt_q;
        if (bin_cnt_q == LAST_BIN) begin
          last1_d   = 1'b1;
          bin_cnt_d = '0;
        end else begin
          bin_cnt_d = bin_cnt_q + AWIDTH'(1);
        end
      end
    end else begin
      bin_cnt_d = bin_cnt_q;
    end
  end

  // Stage 2: sum and present the beat; idle cycles drive all beat fields to zero.
  always_comb begin
    sum_s       = {1'b0, ii_q} + {1'b0, qq_q};
    tvalid_d    = v1_q;
    dout_d      = '0;
    tlast_d     = 1'b0;
    index_d     = '0;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    if (v1_q) begin
      dout_d  = DATAWIDTH'(sum_s);
      tlast_d = last1_q;
      index_d = idx1_q;
      err_d   = err1_q;
      if (last1_q) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        frame_cnt_d = frame_cnt_q;
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Pipeline and framing state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt_q   <= '0;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      err1_q      <= 1'b0;
      idx1_q      <= '0;
      ii_q        <= '0;
      qq_q        <= '0;
      dout_q      <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      index_q     <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      bin_cnt_q   <= bin_cnt_d;
      v1_q        <= v1_d;
      last1_q     <= last1_d;
      err1_q      <= err1_d;
      idx1_q      <= idx1_d;
      ii_q        <= ii_d;
      qq_q        <= qq_d;
      dout_q      <= dout_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      index_q     <= index_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign dout        = dout_q;
  assign dout_tvalid = tvalid_q;
  assign dout_tlast  = tlast_q;
  assign dout_index  = index_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_short   = err_q;

endmodule

// File: tb/tb_flow_power_frame.sv
// Randomized and directed bench for flow_power_frame with a frame-position model
// delayed through a two-entry expectation line.
module tb_flow_power_frame;

  localparam int IW = 16;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int FL = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] din_i = '0;
  logic [IW-1:0] din_q = '0;
  logic          din_tvalid = 1'b0;
  logic          din_sof = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_tvalid;
  logic          dout_tlast;
  logic [AW-1:0] dout_index;
  logic [15:0]   frame_cnt;
  logic          err_short;

  flow_power_frame #(.IW(IW), .DATAWIDTH(DW), .AWIDTH(AW), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .din_i(din_i), .din_q(din_q),
    .din_tvalid(din_tvalid), .din_sof(din_sof), .dout(dout),
    .dout_tvalid(dout_tvalid), .dout_tlast(dout_tlast), .dout_index(dout_index),
    .frame_cnt(frame_cnt), .err_short(err_short)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [63:0] d;
    bit          l;
    int          idx;
    bit          e;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  int    pos = 0;
  int    fc = 0;
  beat_t prev;
  beat_t cur;
  // per-phase observation statistics used by literal pins
  int    n_valid, n_last, n_err, n25, first_idx;

  function automatic beat_t idle_beat();
    beat_t b;
    b.v = 1'b0; b.d = 64'd0; b.l = 1'b0; b.idx = 0; b.e = 1'b0;
    return b;
  endfunction

  task automatic pin(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    n_valid = 0; n_last = 0; n_err = 0; n25 = 0; first_idx = -1;
  endtask

  task automatic step(input bit v, input bit sof, input int i, input int q);
    beat_t  nb;
    longint li, lq;
    din_tvalid = v;
    din_sof    = sof;
    din_i      = 16'(i);
    din_q      = 16'(q);
    @(posedge clk);
    nb = idle_beat();
    if (v) begin
      li   = longint'($signed(16'(i)));
      lq   = longint'($signed(16'(q)));
      nb.v = 1'b1;
      nb.d = 64'(li * li + lq * lq);
      if (sof) begin
        nb.idx = 0;
        nb.e   = (pos != 0);
        pos    = 1;
      end else begin
        nb.idx = pos;
        nb.l   = (pos == FL - 1);
        pos    = (pos + 1) % FL;
      end
    end
    cur  = prev;
    prev = nb;
    if (cur.v && cur.l) fc = (fc + 1) % 65536;
    #1;
    checks++;
    if (dout_tvalid !== cur.v || dout !== cur.d || dout_tlast !== cur.l ||
        int'(dout_index) != cur.idx || err_short !== cur.e || int'(frame_cnt) != fc) begin
      errors++;
      $display("FAIL beat @%0t: got v=%0b d=%0d l=%0b idx=%0d e=%0b fc=%0d expected v=%0b d=%0d l=%0b idx=%0d e=%0b fc=%0d",
               $time, dout_tvalid, dout, dout_tlast, dout_index, err_short, frame_cnt,
               cur.v, cur.d, cur.l, cur.idx, cur.e, fc);
    end
    if (dout_tvalid) begin
      n_valid++;
      if (first_idx < 0) first_idx = int'(dout_index);
      if (dout_tlast) n_last++;
      if (err_short) n_err++;
      if (dout == 64'd25) n25++;
    end
  endtask

  task automatic check_all_zero(input string name);
    pin({name, "_dout"}, dout, 0);
    pin({name, "_ctl"}, {dout_tvalid, dout_tlast, err_short}, 0);
    pin({name, "_idx"}, dout_index, 0);
    pin({name, "_fc"}, frame_cnt, 0);
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    din_tvalid = 1'b0;
    din_sof = 1'b0;
    #1;
    check_all_zero("async_rst");
    prev = idle_beat();
    pos  = 0;
    fc   = 0;
    @(posedge clk);
    #4;
    rst_n = 1'b1;
  endtask

  initial begin
    prev = idle_beat();
    cur  = idle_beat();
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Full frame of 3+4j, first sample carries sof straight after reset.
    clear_stats();
    for (int k = 0; k < FL; k++) step(1'b1, k == 0, 3, 4);
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    pin("frame_n25", n25, 256);
    pin("frame_tlast", n_last, 1);
    pin("frame_first_idx", first_idx, 0);
    pin("frame_no_err", n_err, 0);
    pin("frame_cnt1", frame_cnt, 1);

    // Arithmetic corners.
    step(1'b1, 1'b0, -32768, -32768);
    step(1'b1, 1'b0, 32767, -1);
    pin("corner_min", dout, 64'h0000_0000_8000_0000);
    step(1'b0, 1'b0, 0, 0);
    pin("corner_max", dout, 64'd1073676290);
    step(1'b0, 1'b0, 0, 0);

    // Alternating valid, realigned with sof (aborts the 2-bin partial frame).
    clear_stats();
    for (int k = 0; k < 1024; k++)
      step(k % 2 == 0, k == 0, int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768);
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    pin("toggle_valid", n_valid, 512);
    pin("toggle_tlast", n_last, 2);
    pin("toggle_err", n_err, 1);
    pin("toggle_fc", frame_cnt, 3);

    // Short frame: sof on the 101st sample.
    clear_stats();
    for (int k = 0; k < 356; k++)
      step(1'b1, k == 100, int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768);
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    pin("short_err", n_err, 1);
    pin("short_tlast", n_last, 1);
    pin("short_fc", frame_cnt, 4);

    // Reset at bin 37, then restart.
    for (int k = 0; k < 37; k++) step(1'b1, 1'b0, k, -k);
    mid_reset();
    clear_stats();
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 3, 4);
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    pin("rst_restart_idx", first_idx, 0);
    pin("rst_restart_n", n_valid, 10);
    pin("rst_restart_err", n_err, 0);
    pin("rst_restart_fc", frame_cnt, 0);

    // Random traffic with occasional sof.
    for (int k = 0; k < 3000; k++)
      step($urandom_range(3) != 0, $urandom_range(63) == 0,
           int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768);
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flow_power_frame.md
Name: flow_power_frame

Overview:
Upstream stage of the per-frame argmax block. It takes a continuous complex sample stream (I/Q), computes the instantaneous power I²+Q² in a 2-stage pipeline, and slices the result into fixed-length frames. Each output beat carries dout/dout_tvalid, and the last bin of every frame carries dout_tlast, so the downstream block can run its max/index search over exactly FRAME_LEN bins. A sync input realigns framing, and short frames are flagged.

Parameters:
IW, 16, signed width of each of din_i and din_q.
DATAWIDTH, 64, output power width; must be >= 2*IW+1; the power result is zero-extended into it.
AWIDTH, 8, bin counter width; must satisfy FRAME_LEN <= 2^AWIDTH.
FRAME_LEN, 256, bins per frame; must be >= 2.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
din_i  in  IW  signed in-phase sample
din_q  in  IW  signed quadrature sample
din_tvalid  in  1  input sample valid; no backpressure
din_sof  in  1  start-of-frame sync, sampled only when din_tvalid=1
dout  out  DATAWIDTH  unsigned power I²+Q², zero-extended
dout_tvalid  out  1  output valid
dout_tlast  out  1  last bin of frame, qualified by dout_tvalid
dout_index  out  AWIDTH  bin index of the current output beat
frame_cnt  out  16  completed-frame count, wraps at 2^16
err_short  out  1  one-cycle pulse when a frame is cut short by din_sof

Behaviour:
- Reset (rst_n=0, asynchronous): dout, dout_tvalid, dout_tlast, dout_index, frame_cnt and err_short all go to 0. The pipeline valid bits and bin counter clear, and in-flight samples are discarded. After release, the first valid sample is bin 0.
- Pipeline stage 1 registers i*i and q*q as unsigned 2*IW-bit products, together with the valid, sof and bin-index sideband.
- Pipeline stage 2 registers the sum (2*IW+1 bits, zero-extended to DATAWIDTH) and drives dout_tvalid.
- Fixed latency is 2 cycles from din_tvalid to dout_tvalid. Throughput is 1 sample per clock. Gaps in din_tvalid propagate as gaps in dout_tvalid.
- When dout_tvalid=0: dout=0, dout_tlast=0, dout_index=0.
- Bin counter, advanced on every accepted input (din_tvalid=1):
  - The beat is tagged with index = bin_cnt.
  - tlast is tagged when bin_cnt == FRAME_LEN-1, after which bin_cnt goes to 0.
  - Otherwise bin_cnt increments.
- din_sof=1 with din_tvalid=1:
  - The beat is forced to index 0 and bin_cnt becomes 1.
  - If the prior bin_cnt != 0, the previous frame is abandoned: no tlast is emitted for it, err_short pulses aligned with this beat's output cycle, and frame_cnt does not increment.
  - If the prior bin_cnt == 0, this is a normal frame start: no error.
- din_sof with din_tvalid=0 is ignored.
- frame_cnt increments in the same cycle dout_tvalid=1 and dout_tlast=1 are presented.
- Arithmetic corner: I=Q=-2^(IW-1) gives 2^(2*IW-1). This must be exact, with no overflow and no sign extension.
- Reset mid-frame: the partial frame is lost silently, with no err_short.

Test Plan:
- Reset, then 256 consecutive valid samples I=3, Q=4 -> 2 cycles later 256 beats with dout=25 and dout_index 0..255; dout_tlast only on index 255; frame_cnt 0->1.
- I=-32768, Q=-32768 single beat -> dout=0x80000000 (upper bits zero). I=32767, Q=-1 -> dout=1073676290.
- 512 samples with din_tvalid toggling 1/0 -> output valid pattern identical, delayed 2 cycles; tlast on the 256th and 512th valid beats; frame_cnt=2.
- 100 samples, then din_sof=1 on the 101st -> err_short pulses with that beat, its dout_index=0, no tlast for the aborted frame, frame_cnt unchanged; the next tlast comes 255 beats later.
- din_sof=1 on the very first sample after reset -> index 0, err_short stays 0.
- rst_n pulsed low for 1 cycle at bin 37 of a frame -> all outputs 0 asynchronously; in-flight beats dropped; the next valid sample restarts at index 0 with no err_short.
